// File: rtl/kbd_entry.sv
// Keypad front end: 2-flop sync, debounce, one digit per press,
// shifted into a 3-digit BCD cook-time register.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised samples to accept press/release (1..255)
// Ports:
//   clk        in   system clock
//   clearn     in   synchronous active-low reset
//   kbd[9:0]   in   raw one-hot keypad, asynchronous
//   load_en    in   digit entry permitted
//   entry_clr  in   zero the time register
//   digit      out  last accepted key, BCD
//   key_valid  out  one-cycle pulse per accepted press
//   key_reject out  one-cycle pulse when an accepted press is not shifted in
//   min, sec_tens, sec_ones  out  time register digits
//   time_nz    out  time register non-zero
// Configuration:
//   ENTRY_SEC_CHECK_EN  refuse shifts that would put >5 into sec_tens
module kbd_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] kbd,
    input  logic       load_en,
    input  logic       entry_clr,
    output logic [3:0] digit,
    output logic       key_valid,
    output logic       key_reject,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       time_nz
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [9:0] code, code_n;

    logic [9:0] sync1, ks;

    logic [3:0] digit_n, min_n, tens_n, ones_n;
    logic       valid_n, reject_n, nz_n;

    logic       ks_one, ks_zero, accept, shift_ok;
    logic [3:0] enc;

    // Two-flop synchroniser for the asynchronous keypad.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            sync1 <= '0;
            ks    <= '0;
        end else begin
            sync1 <= kbd;
            ks    <= sync1;
        end
    end

    // Exactly one bit set; zero or several keys count as no key.
    assign ks_one  = (ks != '0) && ((ks & (ks - 10'd1)) == '0);
    assign ks_zero = (ks == '0);

    // One-hot to binary; the latched code is always one-hot.
    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code[i]) enc = 4'(i);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            code  <= code_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ks_one) begin
                    code_n  = ks;
                    cnt_n   = '0;
                    state_n = PRESS;
                end
            end
            PRESS: begin
                if (ks != code) begin
                    state_n = IDLE;
                end else if (cnt == CNT_MAX) begin
                    accept  = 1'b1;
                    state_n = HELD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HELD: begin
                if (ks_zero) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!ks_zero) begin
                    state_n = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Accept action and time register update.
    always_comb begin
        digit_n  = digit;
        valid_n  = 1'b0;
        reject_n = 1'b0;
        min_n    = min;
        tens_n   = sec_tens;
        ones_n   = sec_ones;
        shift_ok = load_en;
`ifdef ENTRY_SEC_CHECK_EN
        // Current sec_ones would become sec_tens; keep it a valid 0..5.
        if (sec_ones > 4'd5) shift_ok = 1'b0;
`endif
        if (accept) begin
            digit_n  = enc;
            valid_n  = 1'b1;
            reject_n = !shift_ok;
            if (shift_ok) begin
                min_n  = sec_tens;
                tens_n = sec_ones;
                ones_n = enc;
            end
        end
        // Clear beats a coincident shift; the pulse and digit still go out.
        if (entry_clr) begin
            min_n  = '0;
            tens_n = '0;
            ones_n = '0;
        end
        nz_n = (min_n | tens_n | ones_n) != '0;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            digit      <= '0;
            key_valid  <= 1'b0;
            key_reject <= 1'b0;
            min        <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            time_nz    <= 1'b0;
        end else begin
            digit      <= digit_n;
            key_valid  <= valid_n;
            key_reject <= reject_n;
            min        <= min_n;
            sec_tens   <= tens_n;
            sec_ones   <= ones_n;
            time_nz    <= nz_n;
        end
    end

endmodule

// File: tb/tb_kbd_entry.sv
// Directed bench for kbd_entry: table of presses plus hand-written
// sequences for clearing, gating, noise, reset and the seconds check.
module tb_kbd_entry;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       clearn;
    logic [9:0] kbd;
    logic       load_en;
    logic       entry_clr;
    logic [3:0] digit;
    logic       key_valid;
    logic       key_reject;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       time_nz;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int rcnt = 0;

    kbd_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk),
        .clearn(clearn),
        .kbd(kbd),
        .load_en(load_en),
        .entry_clr(entry_clr),
        .digit(digit),
        .key_valid(key_valid),
        .key_reject(key_reject),
        .min(min),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .time_nz(time_nz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) vcnt++;
        if (key_reject) rcnt++;
    end

    typedef struct {
        int   key;
        logic len;
        logic clr;
        int   e_min;
        int   e_tens;
        int   e_ones;
        int   e_digit;
        int   e_valid;
        int   e_rej;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        vcnt = 0;
        rcnt = 0;
        kbd = 10'd1 << k;
        cyc(100);
        kbd = '0;
        cyc(100);
    endtask

    task automatic check_reg(input string tag, input int m, input int t,
                             input int o);
        check({tag, " min"}, int'(min), m);
        check({tag, " tens"}, int'(sec_tens), t);
        check({tag, " ones"}, int'(sec_ones), o);
        check({tag, " nz"}, int'(time_nz), (m | t | o) != 0 ? 1 : 0);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{1, 1'b1, 1'b0, 0, 0, 1, 1, 1, 0};
        vt[1] = '{2, 1'b1, 1'b0, 0, 1, 2, 2, 1, 0};
        vt[2] = '{3, 1'b1, 1'b0, 1, 2, 3, 3, 1, 0};
        vt[3] = '{4, 1'b1, 1'b0, 2, 3, 4, 4, 1, 0};
        vt[4] = '{3, 1'b1, 1'b1, 0, 0, 3, 3, 1, 0};
        vt[5] = '{0, 1'b1, 1'b0, 0, 3, 0, 0, 1, 0};
        vt[6] = '{9, 1'b1, 1'b0, 3, 0, 9, 9, 1, 0};
        vt[7] = '{3, 1'b1, 1'b1, 0, 0, 3, 3, 1, 0};
        vt[8] = '{5, 1'b1, 1'b0, 0, 3, 5, 5, 1, 0};

        clearn = 1'b0;
        kbd = '0;
        load_en = 1'b1;
        entry_clr = 1'b0;
        cyc(3);
        check("rst digit", int'(digit), 0);
        check("rst valid", int'(key_valid), 0);
        check("rst reject", int'(key_reject), 0);
        check_reg("rst", 0, 0, 0);
        clearn = 1'b1;
        cyc(2);

        for (int i = 0; i < 9; i++) begin
            load_en = vt[i].len;
            if (vt[i].clr) begin
                entry_clr = 1'b1;
                cyc(1);
                entry_clr = 1'b0;
                cyc(1);
            end
            press(vt[i].key);
            check($sformatf("v%0d valid", i), vcnt, vt[i].e_valid);
            check($sformatf("v%0d reject", i), rcnt, vt[i].e_rej);
            check($sformatf("v%0d digit", i), int'(digit), vt[i].e_digit);
            check_reg($sformatf("v%0d", i), vt[i].e_min, vt[i].e_tens,
                      vt[i].e_ones);
        end

        // Register is 0:35; one-cycle clear.
        entry_clr = 1'b1;
        cyc(1);
        entry_clr = 1'b0;
        check_reg("clr", 0, 0, 0);

        // Gated entry: accepted but rejected.
        load_en = 1'b0;
        press(8);
        check("gate digit", int'(digit), 8);
        check("gate valid", vcnt, 1);
        check("gate reject", rcnt, 1);
        check_reg("gate", 0, 0, 0);
        load_en = 1'b1;

        // Glitch one sample short of debounce.
        vcnt = 0;
        rcnt = 0;
        kbd = 10'd1 << 5;
        cyc(DB - 1);
        kbd = '0;
        cyc(100);
        check("glitch valid", vcnt, 0);

        // Two keys at once is no key.
        kbd = 10'b0000100010;
        cyc(100);
        kbd = '0;
        cyc(100);
        check("multi valid", vcnt, 0);
        check("multi reject", rcnt, 0);
        check_reg("noise", 0, 0, 0);

        // 7 then 0.
        press(7);
        check("d7 valid", vcnt, 1);
        check_reg("d7", 0, 0, 7);
        press(0);
        check("d70 valid", vcnt, 1);
        check("d70 digit", int'(digit), 0);
`ifdef ENTRY_SEC_CHECK_EN
        check("d70 reject", rcnt, 1);
        check_reg("d70", 0, 0, 7);
`else
        check("d70 reject", rcnt, 0);
        check_reg("d70", 0, 7, 0);
`endif

        // Clear held across an accept: clear wins, pulse and digit remain.
        entry_clr = 1'b1;
        press(6);
        entry_clr = 1'b0;
        check("clracc valid", vcnt, 1);
        check("clracc digit", int'(digit), 6);
        check_reg("clracc", 0, 0, 0);

        // Reset while the key is held after an accept.
        vcnt = 0;
        kbd = 10'd1 << 4;
        cyc(50);
        check("held valid", vcnt, 1);
        check("held ones", int'(sec_ones), 4);
        clearn = 1'b0;
        kbd = '0;
        cyc(2);
        check("mid rst digit", int'(digit), 0);
        check_reg("mid rst", 0, 0, 0);
        clearn = 1'b1;
        vcnt = 0;
        cyc(100);
        check("post rst valid", vcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
